// File: rtl/shared_reg_pkg.sv
// shared_reg_pkg: FSM state encoding and a constant-friendly clog2 for the shared register arbiter.
package shared_reg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector; the first set request after i_ptr wins, wrapping.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_onehot,
    output logic [ID_W-1:0]    o_idx,
    output logic               o_any
);

    logic [ID_W-1:0] w_j;

    // Scan farthest-first so the nearest requester after i_ptr is the last write and wins.
    always_comb begin
        w_j   = '0;
        o_idx = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_j = ID_W'((int'(i_ptr) + k) % NUM_REQ);
            if (i_req[w_j]) o_idx = w_j;
        end
    end

    assign o_any    = |i_req;
    assign o_onehot = o_any ? NUM_REQ'(1) << o_idx : '0;

endmodule

// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter: round-robin grant and write sequencer for one shared register.
// Define SHARED_REG_OWNER_EN to add the Owner port (index of the last committed writer).
module shared_reg_arbiter
    import shared_reg_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int WIDTH   = 8,
    localparam int ID_W    = clog2(NUM_REQ)
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [NUM_REQ-1:0]       Req,
    input  logic [NUM_REQ*WIDTH-1:0] WrData,
    output logic [NUM_REQ-1:0]       Grant,
    output logic [NUM_REQ-1:0]       Ack,
    output logic [WIDTH-1:0]         Q,
    output logic                     Busy
`ifdef SHARED_REG_OWNER_EN
    ,
    output logic [ID_W-1:0]          Owner
`endif
);

    state_t             r_state;
    logic [NUM_REQ-1:0] r_grant;
    logic [NUM_REQ-1:0] r_ack;
    logic [WIDTH-1:0]   r_q;
    logic [ID_W-1:0]    r_ptr;
    logic [ID_W-1:0]    r_idx;
    logic [NUM_REQ-1:0] w_onehot;
    logic [ID_W-1:0]    w_idx;
    logic               w_any;
`ifdef SHARED_REG_OWNER_EN
    logic [ID_W-1:0]    r_owner;
    assign Owner = r_owner;
`endif

    rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
        .i_req    (Req),
        .i_ptr    (r_ptr),
        .o_onehot (w_onehot),
        .o_idx    (w_idx),
        .o_any    (w_any)
    );

    // r_idx latches the winner at grant time so later Req changes cannot redirect the write.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_ack   <= '0;
            r_q     <= '0;
            r_ptr   <= ID_W'(NUM_REQ - 1);
            r_idx   <= '0;
`ifdef SHARED_REG_OWNER_EN
            r_owner <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_ack <= '0;
                    if (w_any) begin
                        r_grant <= w_onehot;
                        r_idx   <= w_idx;
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    r_q     <= WrData[r_idx*WIDTH +: WIDTH];
                    r_ack   <= r_grant;
                    r_ptr   <= r_idx;
                    r_state <= HOLD;
`ifdef SHARED_REG_OWNER_EN
                    r_owner <= r_idx;
`endif
                end
                HOLD: begin
                    r_ack <= '0;
                    if (!Req[r_idx]) begin
                        r_grant <= '0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign Grant = r_grant;
    assign Ack   = r_ack;
    assign Q     = r_q;
    assign Busy  = r_state != IDLE;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// tb_shared_reg_arbiter: directed bench for shared_reg_arbiter with hand-computed expectations.
// Define SHARED_REG_OWNER_EN to also exercise the Owner port.
module tb_shared_reg_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] wr_data;
    logic [3:0]  grant;
    logic [3:0]  ack;
    logic [7:0]  q;
    logic        busy;
    int          n_chk = 0;
    int          n_bad = 0;
`ifdef SHARED_REG_OWNER_EN
    logic [1:0]  owner;
`endif

    shared_reg_arbiter #(.NUM_REQ(4), .WIDTH(8)) dut (
        .Clk    (clk),
        .Reset  (rst),
        .Req    (req),
        .WrData (wr_data),
        .Grant  (grant),
        .Ack    (ack),
        .Q      (q),
        .Busy   (busy)
`ifdef SHARED_REG_OWNER_EN
        ,
        .Owner  (owner)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] w_oh;
        rst = 1'b1;
        req = '0;
        wr_data = '0;
        #12;
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_q", 32'(q), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        step();

        // all four requesting: order 0,1,2,3,0 starting from ptr=3
        wr_data = 32'h44_33_22_11;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            w_oh = 4'b0001 << (k % 4);
            step();
            chk("rr_grant", 32'(grant), 32'(w_oh));
            step();
            chk("rr_ack", 32'(ack), 32'(w_oh));
            chk("rr_q", 32'(q), 32'(8'h11 * ((k % 4) + 1)));
            req = req & ~w_oh;
            step();
            chk("rr_ack_low", 32'(ack), 32'h0);
            chk("rr_release", 32'(grant), 32'h0);
            req = req | w_oh;
        end
        req = '0;
        step();

        // commit requester 3 to put ptr at 3, then wrap-around
        req = 4'b1000;
        step();
        chk("w3_grant", 32'(grant), 32'h8);
        step();
        req = '0;
        step();
        req = 4'b1001;
        step();
        chk("wrap_first", 32'(grant), 32'h1);
        step();
        chk("wrap_ack0", 32'(ack), 32'h1);
        req = 4'b1000;
        step();
        chk("wrap_idle", 32'(grant), 32'h0);
        step();
        chk("wrap_second", 32'(grant), 32'h8);
        step();
        chk("wrap_ack3", 32'(ack), 32'h8);
        chk("wrap_q", 32'(q), 32'h44);
        req = '0;
        step();

        // single request on requester 2
        wr_data = 32'h00_A5_00_00;
        req = 4'b0100;
        step();
        chk("s_grant_e0", 32'(grant), 32'h4);
        chk("s_ack_e0", 32'(ack), 32'h0);
        chk("s_busy_e0", 32'(busy), 32'h1);
        chk("s_q_e0", 32'(q), 32'h44);
        step();
        chk("s_q_e1", 32'(q), 32'hA5);
        chk("s_ack_e1", 32'(ack), 32'h4);
        step();
        chk("s_ack_e2", 32'(ack), 32'h0);
        chk("s_grant_e2", 32'(grant), 32'h4);
        chk("s_busy_e2", 32'(busy), 32'h1);
`ifdef SHARED_REG_OWNER_EN
        chk("owner", 32'(owner), 32'h2);
`endif
        req = '0;
        step();
        chk("s_grant_rel", 32'(grant), 32'h0);
        chk("s_busy_rel", 32'(busy), 32'h0);

        // early release during LOAD still commits
        wr_data = 32'h00_00_5A_00;
        req = 4'b0010;
        step();
        chk("e_grant", 32'(grant), 32'h2);
        req = '0;
        wr_data = 32'h00_00_77_00;
        step();
        chk("e_q", 32'(q), 32'h77);
        chk("e_ack", 32'(ack), 32'h2);
        chk("e_busy_hold", 32'(busy), 32'h1);
        step();
        chk("e_ack_low", 32'(ack), 32'h0);
        chk("e_grant_low", 32'(grant), 32'h0);
        chk("e_busy_low", 32'(busy), 32'h0);
        step();
        chk("e_no_ack", 32'(ack), 32'h0);

        // async reset mid-HOLD
        wr_data = 32'h00_3C_00_00;
        req = 4'b0100;
        step();
        step();
        chk("r_q_pre", 32'(q), 32'h3C);
        #2;
        rst = 1'b1;
        #1;
        chk("r_grant", 32'(grant), 32'h0);
        chk("r_ack", 32'(ack), 32'h0);
        chk("r_q", 32'(q), 32'h0);
        chk("r_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        req = 4'b0001;
        step();
        chk("r_regrant", 32'(grant), 32'h1);
        step();
        chk("r_ack0", 32'(ack), 32'h1);
        req = '0;
        step();
        chk("r_end", 32'(busy), 32'h0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
